rr_arb_mux: RTL and testbench

- Parametrised successor to the team's 2-/4-way 32-bit selectors.
- Merges NUM_CH valid/ready request channels onto one registered output channel.
- The source is chosen by fair round-robin arbitration rather than an external select.
- Used wherever several pipeline/cache requesters share one downstream consumer, e.g. I-/D-cache refill requests onto the memory port.

---
 rtl/rr_arb_mux.sv | 94 +++++++++
 tb/tb_rr_arb_mux.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// Round-robin arbiter that merges NUM_CH valid/ready channels onto one registered output.
// The channel granted last drops to lowest priority on the next round.
module rr_arb_mux #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [NUM_CH*WIDTH-1:0] data_i,
   input  logic [NUM_CH-1:0]       valid_i,
   output logic [NUM_CH-1:0]       ready_o,
   output logic [WIDTH-1:0]        data_o,
   output logic                    valid_o,
   output logic [SEL_W-1:0]        grant_o,
   input  logic                    ready_i
);

   localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(NUM_CH - 1);

   logic [WIDTH-1:0] data_q,  data_d;
   logic             valid_q, valid_d;
   logic [SEL_W-1:0] grant_q, grant_d;
   logic [SEL_W-1:0] ptr_q,   ptr_d;

   logic             load_en;
   logic             win_found;
   logic [SEL_W-1:0] win_idx;
   logic [WIDTH-1:0] win_data;
   logic             in_xfer;
   logic             out_xfer;

   // Winner search starts just after the last grant and wraps modulo NUM_CH.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         int unsigned cand;
         cand = (32'(ptr_q) + i) % NUM_CH;
         if (!win_found && valid_i[SEL_W'(cand)]) begin
            win_found = 1'b1;
            win_idx   = SEL_W'(cand);
         end
      end
   end

   assign load_en  = !valid_q || ready_i;
   assign win_data = data_i[32'(win_idx)*WIDTH +: WIDTH];

   always_comb begin
      ready_o = '0;
      if (load_en && win_found && !rst_i) begin
         ready_o[win_idx] = 1'b1;
      end
   end

   assign in_xfer  = |ready_o;
   assign out_xfer = valid_q && ready_i;

   // A new beat always wins over draining the old one, so back-to-back beats have no bubble.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      if (in_xfer) begin
         data_d  = win_data;
         valid_d = 1'b1;
         grant_d = win_idx;
         ptr_d   = win_idx;
      end else if (out_xfer) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         grant_q <= '0;
         ptr_q   <= PTR_RST;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign grant_o = grant_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-channel vector table plus a 3-channel wrap sequence.
module tb_rr_arb_mux;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // 4-channel, 32-bit instance
   logic         rst;
   logic [127:0] data_i;
   logic [3:0]   valid_i;
   logic [3:0]   ready_o;
   logic [31:0]  data_o;
   logic         valid_o;
   logic [1:0]   grant_o;
   logic         ready_i;

   rr_arb_mux #(.WIDTH(32), .NUM_CH(4)) dut (
      .clk_i(clk), .rst_i(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_o(data_o), .valid_o(valid_o), .grant_o(grant_o), .ready_i(ready_i)
   );

   // 3-channel, 8-bit instance for non-power-of-2 wrap
   logic        rst3;
   logic [23:0] data3_i;
   logic [2:0]  valid3_i;
   logic [2:0]  ready3_o;
   logic [7:0]  data3_o;
   logic        valid3_o;
   logic [1:0]  grant3_o;
   logic        ready3_i;

   rr_arb_mux #(.WIDTH(8), .NUM_CH(3)) dut3 (
      .clk_i(clk), .rst_i(rst3), .data_i(data3_i), .valid_i(valid3_i), .ready_o(ready3_o),
      .data_o(data3_o), .valid_o(valid3_o), .grant_o(grant3_o), .ready_i(ready3_i)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  vld;
      logic        rdy;
      logic [31:0] base;
      logic [3:0]  e_rdy;
      logic        e_vo;
      logic        chk_dg;
      logic [31:0] e_data;
      logic [1:0]  e_gnt;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int    exp_g3[9];
      string tag;

      // rst vld rdy base | e_rdy e_vo chk_dg e_data e_gnt
      // reset held with all channels requesting
      tbl.push_back('{1'b1, 4'b1111, 1'b1, 32'h1000,     4'b0000, 1'b0, 1'b1, 32'h0,        2'd0});
      tbl.push_back('{1'b1, 4'b1111, 1'b1, 32'h1000,     4'b0000, 1'b0, 1'b1, 32'h0,        2'd0});
      // first grant after reset is ch0
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 32'h1000,     4'b0001, 1'b1, 1'b1, 32'h1000,     2'd0});
      // single requester ch2
      tbl.push_back('{1'b0, 4'b0100, 1'b1, 32'hCAFE0000, 4'b0100, 1'b1, 1'b1, 32'hCAFE0002, 2'd2});
      // drain
      tbl.push_back('{1'b0, 4'b0000, 1'b1, 32'h0,        4'b0000, 1'b0, 1'b0, 32'h0,        2'd0});
      // re-reset, then full contention 0,1,2,3,0,1 without bubbles
      tbl.push_back('{1'b1, 4'b1111, 1'b1, 32'h1000,     4'b0000, 1'b0, 1'b1, 32'h0,        2'd0});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 32'h1000,     4'b0001, 1'b1, 1'b1, 32'h1000,     2'd0});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 32'h1000,     4'b0010, 1'b1, 1'b1, 32'h1001,     2'd1});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 32'h1000,     4'b0100, 1'b1, 1'b1, 32'h1002,     2'd2});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 32'h1000,     4'b1000, 1'b1, 1'b1, 32'h1003,     2'd3});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 32'h1000,     4'b0001, 1'b1, 1'b1, 32'h1000,     2'd0});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 32'h1000,     4'b0010, 1'b1, 1'b1, 32'h1001,     2'd1});
      // backpressure with ch1 beat held for 3 cycles
      tbl.push_back('{1'b0, 4'b1111, 1'b0, 32'h1000,     4'b0000, 1'b1, 1'b1, 32'h1001,     2'd1});
      tbl.push_back('{1'b0, 4'b1111, 1'b0, 32'h1000,     4'b0000, 1'b1, 1'b1, 32'h1001,     2'd1});
      tbl.push_back('{1'b0, 4'b1111, 1'b0, 32'h1000,     4'b0000, 1'b1, 1'b1, 32'h1001,     2'd1});
      tbl.push_back('{1'b0, 4'b1111, 1'b1, 32'h1000,     4'b0100, 1'b1, 1'b1, 32'h1002,     2'd2});
      // skip and wrap from ptr=2 with ch0/ch1 only
      tbl.push_back('{1'b0, 4'b0011, 1'b1, 32'h2000,     4'b0001, 1'b1, 1'b1, 32'h2000,     2'd0});
      tbl.push_back('{1'b0, 4'b0011, 1'b1, 32'h2000,     4'b0010, 1'b1, 1'b1, 32'h2001,     2'd1});
      tbl.push_back('{1'b0, 4'b0011, 1'b1, 32'h2000,     4'b0001, 1'b1, 1'b1, 32'h2000,     2'd0});
      // stall, then reset mid-operation discards the beat
      tbl.push_back('{1'b0, 4'b1111, 1'b0, 32'h2000,     4'b0000, 1'b1, 1'b1, 32'h2000,     2'd0});
      tbl.push_back('{1'b1, 4'b1111, 1'b0, 32'h2000,     4'b0000, 1'b0, 1'b1, 32'h0,        2'd0});
      tbl.push_back('{1'b0, 4'b1010, 1'b1, 32'h3000,     4'b0010, 1'b1, 1'b1, 32'h3001,     2'd1});
      tbl.push_back('{1'b0, 4'b1010, 1'b1, 32'h3000,     4'b1000, 1'b1, 1'b1, 32'h3003,     2'd3});
      // idle cycles must not move priority
      tbl.push_back('{1'b0, 4'b0000, 1'b0, 32'h3000,     4'b0000, 1'b1, 1'b1, 32'h3003,     2'd3});
      tbl.push_back('{1'b0, 4'b0000, 1'b1, 32'h3000,     4'b0000, 1'b0, 1'b0, 32'h0,        2'd0});
      tbl.push_back('{1'b0, 4'b1010, 1'b1, 32'h3000,     4'b0010, 1'b1, 1'b1, 32'h3001,     2'd1});

      rst      = 1'b1;
      valid_i  = '0;
      data_i   = '0;
      ready_i  = 1'b0;
      rst3     = 1'b1;
      valid3_i = '0;
      data3_i  = '0;
      ready3_i = 1'b1;

      for (int r = 0; r < tbl.size(); r++) begin
         @(negedge clk);
         rst     = tbl[r].rst;
         valid_i = tbl[r].vld;
         ready_i = tbl[r].rdy;
         for (int k = 0; k < 4; k++) data_i[k*32 +: 32] = tbl[r].base + 32'(k);
         #1;
         tag = $sformatf("row%0d_ready_o", r);
         chk(tag, 32'(ready_o), 32'(tbl[r].e_rdy));
         @(posedge clk);
         #1;
         tag = $sformatf("row%0d_valid_o", r);
         chk(tag, 32'(valid_o), 32'(tbl[r].e_vo));
         if (tbl[r].chk_dg) begin
            tag = $sformatf("row%0d_data_o", r);
            chk(tag, data_o, tbl[r].e_data);
            tag = $sformatf("row%0d_grant_o", r);
            chk(tag, 32'(grant_o), 32'(tbl[r].e_gnt));
         end
      end

      // 3-channel: all valid gives 0,1,2,0,1,2 then ch0/ch2 only gives 0,2,0
      exp_g3 = '{0, 1, 2, 0, 1, 2, 0, 2, 0};
      @(negedge clk);
      rst3 = 1'b1;
      @(negedge clk);
      rst3 = 1'b0;
      for (int c = 0; c < 9; c++) begin
         valid3_i = (c < 6) ? 3'b111 : 3'b101;
         for (int k = 0; k < 3; k++) data3_i[k*8 +: 8] = 8'h50 + 8'(k);
         #1;
         tag = $sformatf("ch3_cyc%0d_ready_o", c);
         chk(tag, 32'(ready3_o), 32'(3'b001 << exp_g3[c]));
         @(posedge clk);
         #1;
         tag = $sformatf("ch3_cyc%0d_grant_o", c);
         chk(tag, 32'(grant3_o), 32'(exp_g3[c]));
         tag = $sformatf("ch3_cyc%0d_data_o", c);
         chk(tag, 32'(data3_o), 32'(8'h50 + 8'(exp_g3[c])));
         tag = $sformatf("ch3_cyc%0d_valid_o", c);
         chk(tag, 32'(valid3_o), 32'd1);
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
